// File: rtl/bsg_manycore_pkg.sv
// Manycore network return packet types shared by the tile endpoints.
package bsg_manycore_pkg;

    typedef enum logic [1:0] {
        e_return_credit   = 2'd0,
        e_return_int_wb   = 2'd1,
        e_return_float_wb = 2'd2,
        e_return_ifetch   = 2'd3
    } bsg_manycore_return_packet_type_e;

endpackage

// File: rtl/bsg_vanilla_pkg.sv
// Vanilla tile constants: CSR map and icache window select bit.
package bsg_vanilla_pkg;

    typedef enum logic [2:0] {
        e_csr_freeze      = 3'd0,
        e_csr_tgo_x       = 3'd1,
        e_csr_tgo_y       = 3'd2,
        e_csr_pc_init     = 3'd3,
        e_csr_dram_enable = 3'd4
    } csr_offset_e;

    localparam int csr_base_addr_gp  = 'h2000;
    localparam int csr_count_gp      = 5;
    localparam int icache_sel_bit_gp = 22;

endpackage

// File: rtl/network_rx_pkg.sv
// Local types for the receive responder: decode targets and response metadata.
package network_rx_pkg;

    import bsg_manycore_pkg::*;

    typedef enum logic [1:0] {
        e_tgt_dmem    = 2'd0,
        e_tgt_icache  = 2'd1,
        e_tgt_csr     = 2'd2,
        e_tgt_invalid = 2'd3
    } rx_target_e;

    typedef struct packed {
        bsg_manycore_return_packet_type_e pkt_type;
        logic [4:0]                       reg_id;
    } resp_meta_s;

endpackage

// File: rtl/network_rx_if.sv
// Endpoint <-> receive responder link: incoming requests and outgoing returns.
interface network_rx_if
    import bsg_manycore_pkg::*;
#(
    parameter int data_width_p = 32,
    parameter int addr_width_p = 28
);
    logic                             packet_v;
    logic                             packet_we;
    logic [addr_width_p-1:0]          packet_addr;
    logic [data_width_p-1:0]          packet_data;
    logic [data_width_p/8-1:0]        packet_mask;
    logic [4:0]                       packet_reg_id;
    logic                             packet_float_wb;
    logic                             packet_yumi;

    logic                             returning_v;
    bsg_manycore_return_packet_type_e returning_pkt_type;
    logic [data_width_p-1:0]          returning_data;
    logic [4:0]                       returning_reg_id;
    logic                             returning_ready;

    modport master (
        output packet_v, packet_we, packet_addr, packet_data, packet_mask,
               packet_reg_id, packet_float_wb, returning_ready,
        input  packet_yumi, returning_v, returning_pkt_type, returning_data,
               returning_reg_id
    );

    modport slave (
        input  packet_v, packet_we, packet_addr, packet_data, packet_mask,
               packet_reg_id, packet_float_wb, returning_ready,
        output packet_yumi, returning_v, returning_pkt_type, returning_data,
               returning_reg_id
    );
endinterface

// File: rtl/network_rx_csr.sv
// Tile CSR file written and read by remote packets; freeze comes out of reset set.
module network_rx_csr
    import bsg_vanilla_pkg::*;
#(
    parameter int data_width_p   = 32,
    parameter int x_cord_width_p = 7,
    parameter int y_cord_width_p = 7,
    parameter int pc_width_p     = 22
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      we,
    input  csr_offset_e               offset,
    input  logic [data_width_p-1:0]   wdata,
    output logic [data_width_p-1:0]   rdata,
    output logic                      freeze,
    output logic [x_cord_width_p-1:0] tgo_x,
    output logic [y_cord_width_p-1:0] tgo_y,
    output logic [pc_width_p-1:0]     pc_init,
    output logic                      dram_enable
);
    // Only the low bits of each CSR are architected; the rest of the word is dropped.
    logic unused_wdata;
    assign unused_wdata = ^wdata[data_width_p-1:pc_width_p];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            freeze      <= 1'b1;
            tgo_x       <= '0;
            tgo_y       <= '0;
            pc_init     <= '0;
            dram_enable <= 1'b0;
        end else if (we) begin
            case (offset)
                e_csr_freeze:      freeze      <= wdata[0];
                e_csr_tgo_x:       tgo_x       <= wdata[x_cord_width_p-1:0];
                e_csr_tgo_y:       tgo_y       <= wdata[y_cord_width_p-1:0];
                e_csr_pc_init:     pc_init     <= wdata[pc_width_p-1:0];
                e_csr_dram_enable: dram_enable <= wdata[0];
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        case (offset)
            e_csr_freeze:      rdata = data_width_p'(freeze);
            e_csr_tgo_x:       rdata = data_width_p'(tgo_x);
            e_csr_tgo_y:       rdata = data_width_p'(tgo_y);
            e_csr_pc_init:     rdata = data_width_p'(pc_init);
            e_csr_dram_enable: rdata = data_width_p'(dram_enable);
            default:           rdata = '0;
        endcase
    end
endmodule

// File: rtl/network_rx.sv
// Remote request responder: decodes EPA to DMEM / icache / CSR, returns one packet per request.
module network_rx
    import bsg_manycore_pkg::*;
    import bsg_vanilla_pkg::*;
    import network_rx_pkg::*;
#(
    parameter int data_width_p       = 32,
    parameter int addr_width_p       = 28,
    parameter int x_cord_width_p     = 7,
    parameter int y_cord_width_p     = 7,
    parameter int dmem_size_p        = 1024,
    parameter int icache_entries_p   = 1024,
    parameter int icache_tag_width_p = 12,
    localparam int dmem_addr_width_lp = $clog2(dmem_size_p),
    localparam int pc_width_lp        = icache_tag_width_p + $clog2(icache_entries_p)
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    network_rx_if.slave                   link,

    output logic                          dmem_v_o,
    output logic                          dmem_w_o,
    output logic [dmem_addr_width_lp-1:0] dmem_addr_o,
    output logic [data_width_p-1:0]       dmem_data_o,
    output logic [data_width_p/8-1:0]     dmem_mask_o,
    input  logic                          dmem_yumi_i,
    input  logic [data_width_p-1:0]       dmem_data_i,

    output logic                          icache_v_o,
    output logic [pc_width_lp-1:0]        icache_pc_o,
    output logic [data_width_p-1:0]       icache_instr_o,
    input  logic                          icache_yumi_i,

    output logic                          freeze_o,
    output logic [x_cord_width_p-1:0]     tgo_x_o,
    output logic [y_cord_width_p-1:0]     tgo_y_o,
    output logic [pc_width_lp-1:0]        pc_init_val_o,
    output logic                          dram_enable_o,
    output logic                          invalid_epa_access_o
);
    localparam logic [addr_width_p-1:0] csr_base_lp  = addr_width_p'(csr_base_addr_gp);
    localparam logic [addr_width_p-1:0] csr_count_lp = addr_width_p'(csr_count_gp);

    // ---------------- decode ----------------
    logic [addr_width_p-1:0] csr_off;
    logic                    in_dmem, in_csr, in_icache;
    rx_target_e              tgt;

    assign csr_off   = link.packet_addr - csr_base_lp;
    assign in_dmem   = (link.packet_addr[addr_width_p-1:dmem_addr_width_lp] == '0);
    assign in_csr    = (csr_off < csr_count_lp);
    assign in_icache = link.packet_addr[icache_sel_bit_gp];

    // The icache window is write-only; loads from it fall through to INVALID.
    always_comb begin
        tgt = e_tgt_invalid;
        if (in_dmem)                         tgt = e_tgt_dmem;
        else if (in_csr)                     tgt = e_tgt_csr;
        else if (in_icache && link.packet_we) tgt = e_tgt_icache;
    end

    // ---------------- handshake ----------------
    logic       resp_v_r, live_r;
    resp_meta_s meta_r, meta_n;
    logic [data_width_p-1:0] data_r, data_n;
    logic       slot_free, req_go, tgt_ready, accept;

    assign slot_free = ~resp_v_r | link.returning_ready;
    assign req_go    = reset_n_i & link.packet_v & slot_free;

    always_comb begin
        tgt_ready = 1'b1;
        case (tgt)
            e_tgt_dmem:   tgt_ready = dmem_yumi_i;
            e_tgt_icache: tgt_ready = icache_yumi_i;
            default:      tgt_ready = 1'b1;
        endcase
    end

    assign accept               = req_go & tgt_ready;
    assign link.packet_yumi     = accept;
    assign invalid_epa_access_o = accept & (tgt == e_tgt_invalid);

    assign dmem_v_o    = req_go & (tgt == e_tgt_dmem);
    assign dmem_w_o    = link.packet_we;
    assign dmem_addr_o = link.packet_addr[dmem_addr_width_lp-1:0];
    assign dmem_data_o = link.packet_data;
    assign dmem_mask_o = link.packet_mask;

    assign icache_v_o     = req_go & (tgt == e_tgt_icache);
    assign icache_pc_o    = link.packet_addr[pc_width_lp-1:0];
    assign icache_instr_o = link.packet_data;

    // ---------------- CSRs ----------------
    logic [data_width_p-1:0] csr_rdata;

    network_rx_csr #(
        .data_width_p  (data_width_p),
        .x_cord_width_p(x_cord_width_p),
        .y_cord_width_p(y_cord_width_p),
        .pc_width_p    (pc_width_lp)
    ) csr (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .we         (accept & (tgt == e_tgt_csr) & link.packet_we),
        .offset     (csr_offset_e'(csr_off[2:0])),
        .wdata      (link.packet_data),
        .rdata      (csr_rdata),
        .freeze     (freeze_o),
        .tgo_x      (tgo_x_o),
        .tgo_y      (tgo_y_o),
        .pc_init    (pc_init_val_o),
        .dram_enable(dram_enable_o)
    );

    // ---------------- response slot ----------------
    always_comb begin
        meta_n.reg_id = link.packet_reg_id;
        if (link.packet_we)            meta_n.pkt_type = e_return_credit;
        else if (link.packet_float_wb) meta_n.pkt_type = e_return_float_wb;
        else                           meta_n.pkt_type = e_return_int_wb;
        data_n = '0;
        if (!link.packet_we && tgt == e_tgt_csr) data_n = csr_rdata;
    end

    // A DMEM load forwards dmem_data_i live for one cycle; if the return stalls the
    // word is captured into data_r before the DMEM read port moves on.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            resp_v_r <= 1'b0;
            live_r   <= 1'b0;
            meta_r   <= '0;
            data_r   <= '0;
        end else if (accept) begin
            resp_v_r <= 1'b1;
            live_r   <= (tgt == e_tgt_dmem) & ~link.packet_we;
            meta_r   <= meta_n;
            data_r   <= data_n;
        end else if (link.returning_ready) begin
            resp_v_r <= 1'b0;
            live_r   <= 1'b0;
        end else if (live_r) begin
            data_r   <= dmem_data_i;
            live_r   <= 1'b0;
        end
    end

    assign link.returning_v        = resp_v_r;
    assign link.returning_pkt_type = meta_r.pkt_type;
    assign link.returning_reg_id   = meta_r.reg_id;
    assign link.returning_data     = live_r ? dmem_data_i : data_r;
endmodule

// File: tb/tb_network_rx.sv
// Self-checking bench for network_rx: directed scenarios plus a randomized run against a reference model.
module tb_network_rx;
    import bsg_manycore_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_clr;
    logic        dmem_v_o, dmem_w_o, dmem_yumi_i;
    logic [9:0]  dmem_addr_o;
    logic [31:0] dmem_data_o, dmem_data_i;
    logic [3:0]  dmem_mask_o;
    logic        icache_v_o, icache_yumi_i;
    logic [21:0] icache_pc_o, pc_init_val_o;
    logic [31:0] icache_instr_o;
    logic        freeze_o, dram_enable_o, invalid_epa_access_o;
    logic [6:0]  tgo_x_o, tgo_y_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    network_rx_if #(.data_width_p(32), .addr_width_p(28)) link ();

    network_rx dut (
        .clk_i(clk), .reset_n_i(rst_n), .link(link),
        .dmem_v_o(dmem_v_o), .dmem_w_o(dmem_w_o), .dmem_addr_o(dmem_addr_o),
        .dmem_data_o(dmem_data_o), .dmem_mask_o(dmem_mask_o),
        .dmem_yumi_i(dmem_yumi_i), .dmem_data_i(dmem_data_i),
        .icache_v_o(icache_v_o), .icache_pc_o(icache_pc_o),
        .icache_instr_o(icache_instr_o), .icache_yumi_i(icache_yumi_i),
        .freeze_o(freeze_o), .tgo_x_o(tgo_x_o), .tgo_y_o(tgo_y_o),
        .pc_init_val_o(pc_init_val_o), .dram_enable_o(dram_enable_o),
        .invalid_epa_access_o(invalid_epa_access_o)
    );

    // DMEM environment: read data valid only the cycle after a granted load, junk otherwise.
    logic [31:0] mem [1024];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
        end else if (dmem_v_o && dmem_yumi_i && dmem_w_o) begin
            for (int b = 0; b < 4; b++)
                if (dmem_mask_o[b]) mem[dmem_addr_o][8*b +: 8] <= dmem_data_o[8*b +: 8];
        end
        if (dmem_v_o && dmem_yumi_i && !dmem_w_o) dmem_data_i <= mem[dmem_addr_o];
        else                                      dmem_data_i <= $urandom;
    end

    // Reference state
    logic [31:0] ref_mem [1024];
    logic        ref_freeze, ref_dram;
    logic [6:0]  ref_tgo_x, ref_tgo_y;
    logic [21:0] ref_pc;

    typedef struct {
        bsg_manycore_return_packet_type_e t;
        logic [4:0]  r;
        logic [31:0] d;
        logic        ld;
    } exp_t;
    exp_t q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        link.packet_v = 1'b0; link.packet_we = 1'b0; link.packet_addr = '0;
        link.packet_data = '0; link.packet_mask = '0; link.packet_reg_id = '0;
        link.packet_float_wb = 1'b0;
    endtask

    task automatic req(input logic we, input logic [27:0] a, input logic [31:0] d,
                       input logic [3:0] m, input logic [4:0] r, input logic f);
        link.packet_v = 1'b1; link.packet_we = we; link.packet_addr = a;
        link.packet_data = d; link.packet_mask = m; link.packet_reg_id = r;
        link.packet_float_wb = f;
    endtask

    // 0 dmem, 1 icache, 2 csr, 3 invalid
    function automatic int tgt_of(input logic [27:0] a, input logic we);
        if (32'(a) < 1024) return 0;
        if (32'(a) >= 32'h2000 && 32'(a) <= 32'h2004) return 2;
        if (a[22] && we) return 1;
        return 3;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; mem_clr = 1'b1;
        req(1'b1, 28'h2000, 32'h0, 4'hF, 5'd0, 1'b0);
        link.returning_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (freeze_o !== 1'b1) begin errors++; $display("FAIL reset_freeze got %b want 1", freeze_o); end
        checks++; if (link.returning_v !== 1'b0) begin errors++; $display("FAIL reset_ret_v got %b want 0", link.returning_v); end
        checks++; if (link.packet_yumi !== 1'b0) begin errors++; $display("FAIL reset_yumi got %b want 0", link.packet_yumi); end
        checks++; if ({tgo_x_o, tgo_y_o, pc_init_val_o, dram_enable_o} !== '0) begin
            errors++; $display("FAIL reset_csrs got %h want 0", {tgo_x_o, tgo_y_o, pc_init_val_o, dram_enable_o}); end
        mem_clr = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (link.packet_yumi !== 1'b1) begin errors++; $display("FAIL freeze_wr_yumi got %b want 1", link.packet_yumi); end
        tick(); idle();
        @(negedge clk);
        checks++; if (freeze_o !== 1'b0) begin errors++; $display("FAIL freeze_cleared got %b want 0", freeze_o); end
        checks++; if (link.returning_v !== 1'b1 || link.returning_pkt_type !== e_return_credit || link.returning_data !== 32'h0) begin
            errors++; $display("FAIL freeze_credit got v=%b t=%0d d=%h want v=1 t=0 d=0",
                               link.returning_v, link.returning_pkt_type, link.returning_data); end
    endtask

    task automatic test_dmem_store();
        tick();
        req(1'b1, 28'h5, 32'hDEADBEEF, 4'hF, 5'd0, 1'b0);
        dmem_yumi_i = 1'b1; link.returning_ready = 1'b1;
        @(negedge clk);
        checks++; if ({dmem_v_o, dmem_w_o, link.packet_yumi, icache_v_o} !== 4'b1110) begin
            errors++; $display("FAIL st_ctrl got v/w/yumi/ic=%b want 1110", {dmem_v_o, dmem_w_o, link.packet_yumi, icache_v_o}); end
        checks++; if (dmem_addr_o !== 10'h5 || dmem_data_o !== 32'hDEADBEEF || dmem_mask_o !== 4'hF) begin
            errors++; $display("FAIL st_bus got a=%h d=%h m=%h want 5 deadbeef f", dmem_addr_o, dmem_data_o, dmem_mask_o); end
        ref_mem[5] = 32'hDEADBEEF;
        tick(); idle();
        @(negedge clk);
        checks++; if (link.returning_v !== 1'b1 || link.returning_pkt_type !== e_return_credit || link.returning_data !== 32'h0) begin
            errors++; $display("FAIL st_credit got v=%b t=%0d d=%h want 1 0 0",
                               link.returning_v, link.returning_pkt_type, link.returning_data); end
    endtask

    task automatic test_dmem_load_held();
        tick();
        req(1'b0, 28'h5, $urandom, 4'h0, 5'd7, 1'b0);
        link.returning_ready = 1'b0;
        @(negedge clk);
        checks++; if ({link.packet_yumi, dmem_v_o, dmem_w_o} !== 3'b110) begin
            errors++; $display("FAIL ld_issue got yumi/v/w=%b want 110", {link.packet_yumi, dmem_v_o, dmem_w_o}); end
        tick();
        req(1'b0, 28'h2001, 32'h0, 4'h0, 5'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (link.returning_v !== 1'b1 || link.returning_data !== ref_mem[5] ||
                          link.returning_pkt_type !== e_return_int_wb || link.returning_reg_id !== 5'd7) begin
                errors++; $display("FAIL ld_held[%0d] got v=%b d=%h t=%0d r=%0d want 1 %h 1 7", i, link.returning_v,
                                   link.returning_data, link.returning_pkt_type, link.returning_reg_id, ref_mem[5]); end
            checks++; if (link.packet_yumi !== 1'b0) begin errors++; $display("FAIL ld_held_yumi[%0d] got %b want 0", i, link.packet_yumi); end
            tick();
        end
        link.returning_ready = 1'b1;
        @(negedge clk);
        checks++; if (link.returning_data !== 32'hDEADBEEF || link.packet_yumi !== 1'b1) begin
            errors++; $display("FAIL ld_drain got d=%h yumi=%b want deadbeef 1", link.returning_data, link.packet_yumi); end
        tick(); idle();
        @(negedge clk);
        checks++; if (link.returning_v !== 1'b1 || link.returning_reg_id !== 5'd3 || link.returning_data !== 32'h0 ||
                      link.returning_pkt_type !== e_return_int_wb) begin
            errors++; $display("FAIL csr_ld_tgo_x got v=%b r=%0d d=%h t=%0d want 1 3 0 1", link.returning_v,
                               link.returning_reg_id, link.returning_data, link.returning_pkt_type); end
    endtask

    task automatic test_csr_roundtrip();
        tick();
        req(1'b1, 28'h2003, 32'h1234, 4'h0, 5'd0, 1'b0);
        @(negedge clk);
        checks++; if (link.packet_yumi !== 1'b1) begin errors++; $display("FAIL pc_wr_yumi got %b want 1", link.packet_yumi); end
        tick();
        req(1'b0, 28'h2003, 32'h0, 4'h0, 5'd9, 1'b1);
        @(negedge clk);
        checks++; if (pc_init_val_o !== 22'h1234) begin errors++; $display("FAIL pc_init got %h want 1234", pc_init_val_o); end
        checks++; if (link.returning_pkt_type !== e_return_credit || link.packet_yumi !== 1'b1) begin
            errors++; $display("FAIL pc_wr_credit got t=%0d yumi=%b want 0 1", link.returning_pkt_type, link.packet_yumi); end
        tick(); idle();
        @(negedge clk);
        checks++; if (link.returning_pkt_type !== e_return_float_wb || link.returning_data !== 32'h1234 ||
                      link.returning_reg_id !== 5'd9) begin
            errors++; $display("FAIL pc_rd got t=%0d d=%h r=%0d want 2 1234 9", link.returning_pkt_type,
                               link.returning_data, link.returning_reg_id); end
    endtask

    task automatic test_invalid_icache();
        tick();
        req(1'b1, 28'h3000, $urandom, 4'hF, 5'd0, 1'b0);
        icache_yumi_i = 1'b1;
        @(negedge clk);
        checks++; if ({invalid_epa_access_o, dmem_v_o, icache_v_o, link.packet_yumi} !== 4'b1001) begin
            errors++; $display("FAIL inv_st got inv/dv/iv/yumi=%b want 1001",
                               {invalid_epa_access_o, dmem_v_o, icache_v_o, link.packet_yumi}); end
        tick();
        req(1'b1, 28'h400155, 32'hCAFEF00D, 4'h0, 5'd0, 1'b0);
        icache_yumi_i = 1'b0;
        @(negedge clk);
        checks++; if (invalid_epa_access_o !== 1'b0 || link.returning_pkt_type !== e_return_credit || link.returning_v !== 1'b1) begin
            errors++; $display("FAIL inv_credit got inv=%b v=%b t=%0d want 0 1 0", invalid_epa_access_o,
                               link.returning_v, link.returning_pkt_type); end
        checks++; if (icache_v_o !== 1'b1 || link.packet_yumi !== 1'b0 || icache_pc_o !== 22'h155 || icache_instr_o !== 32'hCAFEF00D) begin
            errors++; $display("FAIL ic_stall got v=%b yumi=%b pc=%h i=%h want 1 0 155 cafef00d", icache_v_o,
                               link.packet_yumi, icache_pc_o, icache_instr_o); end
        tick();
        icache_yumi_i = 1'b1;
        @(negedge clk);
        checks++; if (link.packet_yumi !== 1'b1) begin errors++; $display("FAIL ic_accept got %b want 1", link.packet_yumi); end
        tick();
        req(1'b0, 28'h400000, 32'h0, 4'h0, 5'd4, 1'b0);
        @(negedge clk);
        checks++; if ({icache_v_o, invalid_epa_access_o, link.packet_yumi} !== 3'b011) begin
            errors++; $display("FAIL ic_ld got iv/inv/yumi=%b want 011", {icache_v_o, invalid_epa_access_o, link.packet_yumi}); end
        tick(); idle();
        @(negedge clk);
        checks++; if (link.returning_pkt_type !== e_return_int_wb || link.returning_data !== 32'h0 || link.returning_reg_id !== 5'd4) begin
            errors++; $display("FAIL ic_ld_ret got t=%0d d=%h r=%0d want 1 0 4", link.returning_pkt_type,
                               link.returning_data, link.returning_reg_id); end
    endtask

    task automatic test_stall_reset();
        tick();
        req(1'b0, 28'h6, 32'h0, 4'h0, 5'd1, 1'b0);
        dmem_yumi_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (dmem_v_o !== 1'b1 || link.packet_yumi !== 1'b0) begin
                errors++; $display("FAIL stall[%0d] got v=%b yumi=%b want 1 0", i, dmem_v_o, link.packet_yumi); end
            tick();
        end
        dmem_yumi_i = 1'b1;
        @(negedge clk);
        checks++; if (link.packet_yumi !== 1'b1) begin errors++; $display("FAIL b2b_first got %b want 1", link.packet_yumi); end
        tick();
        req(1'b0, 28'h7, 32'h0, 4'h0, 5'd2, 1'b0);
        @(negedge clk);
        checks++; if (link.packet_yumi !== 1'b1 || link.returning_data !== ref_mem[6] || link.returning_reg_id !== 5'd1) begin
            errors++; $display("FAIL b2b_second got yumi=%b d=%h r=%0d want 1 %h 1", link.packet_yumi,
                               link.returning_data, link.returning_reg_id, ref_mem[6]); end
        tick(); idle();
        link.returning_ready = 1'b0;
        @(negedge clk);
        checks++; if (link.returning_v !== 1'b1 || link.returning_reg_id !== 5'd2) begin
            errors++; $display("FAIL pend got v=%b r=%0d want 1 2", link.returning_v, link.returning_reg_id); end
        #1;
        rst_n = 1'b0;
        req(1'b1, 28'h2001, 32'h55, 4'hF, 5'd0, 1'b0);
        link.returning_ready = 1'b1;
        #1;
        checks++; if (link.returning_v !== 1'b0 || link.packet_yumi !== 1'b0 || freeze_o !== 1'b1) begin
            errors++; $display("FAIL async_rst got v=%b yumi=%b frz=%b want 0 0 1", link.returning_v,
                               link.packet_yumi, freeze_o); end
        idle();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [27:0] a;
        logic        go, rdy, yumi_exp;
        int          t;
        exp_t        e;
        rst_n = 1'b0; idle();
        tick(); tick();
        rst_n = 1'b1;
        q.delete();
        ref_freeze = 1'b1; ref_tgo_x = '0; ref_tgo_y = '0; ref_pc = '0; ref_dram = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            tick();
            case ($urandom_range(0, 3))
                0: a = 28'($urandom_range(0, 15));
                1: a = 28'h2000 + 28'($urandom_range(0, 4));
                2: a = 28'h400000 | 28'($urandom_range(0, 32'h3FFFFF));
                default: case ($urandom_range(0, 3))
                    0: a = 28'h3000;
                    1: a = 28'h2005;
                    2: a = 28'h400;
                    default: a = 28'h1FFF;
                endcase
            endcase
            req(1'($urandom), a, $urandom, 4'($urandom), 5'($urandom), 1'($urandom));
            link.packet_v        = ($urandom_range(0, 3) != 0);
            link.returning_ready = ($urandom_range(0, 3) != 0);
            dmem_yumi_i          = ($urandom_range(0, 3) != 0);
            icache_yumi_i        = ($urandom_range(0, 3) != 0);
            @(negedge clk);

            checks++; if ({freeze_o, tgo_x_o, tgo_y_o, pc_init_val_o, dram_enable_o} !==
                          {ref_freeze, ref_tgo_x, ref_tgo_y, ref_pc, ref_dram}) begin
                errors++; $display("FAIL rnd_csr cyc %0d got %h want %h", cyc,
                    {freeze_o, tgo_x_o, tgo_y_o, pc_init_val_o, dram_enable_o},
                    {ref_freeze, ref_tgo_x, ref_tgo_y, ref_pc, ref_dram}); end
            checks++; if (link.returning_v !== (q.size() != 0)) begin
                errors++; $display("FAIL rnd_ret_v cyc %0d got %b want %b", cyc, link.returning_v, q.size() != 0); end
            if (q.size() != 0) begin
                e = q[0];
                checks++; if (link.returning_pkt_type !== e.t || link.returning_data !== e.d ||
                              (e.ld && link.returning_reg_id !== e.r)) begin
                    errors++; $display("FAIL rnd_ret cyc %0d got t=%0d d=%h r=%0d want t=%0d d=%h r=%0d", cyc,
                        link.returning_pkt_type, link.returning_data, link.returning_reg_id, e.t, e.d, e.r); end
            end

            t        = tgt_of(a, link.packet_we);
            go       = link.packet_v && (q.size() == 0 || link.returning_ready);
            rdy      = (t == 0) ? dmem_yumi_i : (t == 1) ? icache_yumi_i : 1'b1;
            yumi_exp = go && rdy;
            checks++; if ({link.packet_yumi, dmem_v_o, icache_v_o, invalid_epa_access_o} !==
                          {yumi_exp, go && t == 0, go && t == 1, yumi_exp && t == 3}) begin
                errors++; $display("FAIL rnd_ctrl cyc %0d addr %h got yumi/dv/iv/inv=%b want %b", cyc, a,
                    {link.packet_yumi, dmem_v_o, icache_v_o, invalid_epa_access_o},
                    {yumi_exp, go && t == 0, go && t == 1, yumi_exp && t == 3}); end

            if (q.size() != 0 && link.returning_ready) void'(q.pop_front());
            if (yumi_exp) begin
                e.r  = link.packet_reg_id;
                e.ld = !link.packet_we;
                e.d  = '0;
                e.t  = link.packet_we ? e_return_credit : link.packet_float_wb ? e_return_float_wb : e_return_int_wb;
                if (!link.packet_we && t == 0) e.d = ref_mem[a[9:0]];
                if (!link.packet_we && t == 2) begin
                    case (a[2:0])
                        3'd0: e.d = {31'd0, ref_freeze};
                        3'd1: e.d = {25'd0, ref_tgo_x};
                        3'd2: e.d = {25'd0, ref_tgo_y};
                        3'd3: e.d = {10'd0, ref_pc};
                        default: e.d = {31'd0, ref_dram};
                    endcase
                end
                q.push_back(e);
                if (link.packet_we && t == 0)
                    for (int b = 0; b < 4; b++)
                        if (link.packet_mask[b]) ref_mem[a[9:0]][8*b +: 8] = link.packet_data[8*b +: 8];
                if (link.packet_we && t == 2) begin
                    case (a[2:0])
                        3'd0: ref_freeze = link.packet_data[0];
                        3'd1: ref_tgo_x  = link.packet_data[6:0];
                        3'd2: ref_tgo_y  = link.packet_data[6:0];
                        3'd3: ref_pc     = link.packet_data[21:0];
                        default: ref_dram = link.packet_data[0];
                    endcase
                end
                if (t == 1) begin
                    checks++; if (icache_pc_o !== a[21:0] || icache_instr_o !== link.packet_data) begin
                        errors++; $display("FAIL rnd_icache cyc %0d got pc=%h i=%h want %h %h", cyc,
                                           icache_pc_o, icache_instr_o, a[21:0], link.packet_data); end
                end
            end
        end
        tick(); idle();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
        idle();
        dmem_yumi_i = 1'b0; icache_yumi_i = 1'b0; link.returning_ready = 1'b0;
        test_reset();
        test_dmem_store();
        test_dmem_load_held();
        test_csr_roundtrip();
        test_invalid_icache();
        test_stall_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/network_rx.md
Name: network_rx

Overview:
- Receive-side responder for the vanilla tile. It accepts incoming remote request packets (store, load) from the endpoint and decodes the EPA into one of three local targets: DMEM, icache write port, or tile CSRs.
- It performs the access and returns exactly one return packet per request.
- It is the counterpart of the tile's transmit path. It owns the CSRs that the transmit path consumes: freeze, tgo_x/y, dram_enable and pc_init.

Parameters:
- data_width_p, 32, word width.
- addr_width_p, 28, EPA word-address width.
- x_cord_width_p, 7, X coordinate width.
- y_cord_width_p, 7, Y coordinate width.
- dmem_size_p, 1024, DMEM capacity in words.
- icache_entries_p, 1024, icache depth.
- icache_tag_width_p, 12, icache tag width; pc_width_lp = tag + log2(entries) = 22.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  async active-low reset
- packet_v_i  in  1  incoming request valid
- packet_we_i  in  1  1 = store, 0 = load
- packet_addr_i  in  addr_width_p  EPA word address
- packet_data_i  in  data_width_p  store data
- packet_mask_i  in  data_width_p/8  byte mask
- packet_reg_id_i  in  5  load destination register
- packet_float_wb_i  in  1  load targets the FP register file
- packet_yumi_o  out  1  request consumed
- dmem_v_o, dmem_w_o  out  1 each  DMEM request, write enable
- dmem_addr_o  out  log2(dmem_size_p)  DMEM word address
- dmem_data_o, dmem_mask_o  out  data, mask  DMEM write data and mask
- dmem_yumi_i  in  1  core grants DMEM port this cycle
- dmem_data_i  in  data_width_p  read data, valid the cycle after grant only
- icache_v_o  out  1  icache write strobe
- icache_pc_o  out  pc_width_lp  icache write address
- icache_instr_o  out  data_width_p  icache write data
- icache_yumi_i  in  1  icache write accepted
- returning_v_o  out  1  return packet valid
- returning_pkt_type_o  out  bsg_manycore_return_packet_type_e  return packet type
- returning_data_o  out  data_width_p  return data
- returning_reg_id_o  out  5  return register id
- returning_ready_i  in  1  endpoint takes return packet
- freeze_o  out  1  tile freeze CSR
- tgo_x_o, tgo_y_o  out  coordinate widths  tile-group origin CSRs
- pc_init_val_o  out  pc_width_lp  reset PC CSR
- dram_enable_o  out  1  DRAM enable CSR
- invalid_epa_access_o  out  1  one-cycle pulse on an unmapped access

Behaviour:
- Address decode on packet_addr_i, word addresses:
  - DMEM when addr < dmem_size_p.
  - ICACHE when bit 22 is set (stores only).
  - CSR when addr is 0x2000..0x2004, at offsets 0 freeze, 1 tgo_x, 2 tgo_y, 3 pc_init, 4 dram_enable.
  - Everything else, and icache loads, is INVALID.
- Response register (resp_v_r, type, reg_id, data_r, live_r). The slot is free when ~resp_v_r | returning_ready_i.
- Accept (packet_yumi_o) requires packet_v_i, a free slot, and the target's readiness:
  - DMEM: needs dmem_yumi_i.
  - ICACHE: needs icache_yumi_i.
  - CSR and INVALID: always ready.
- Gating: dmem_v_o and icache_v_o assert only when packet_v_i and the slot is free. They are never asserted for INVALID.
- Side effects happen only in the accept cycle N:
  - DMEM: write or read issued.
  - ICACHE: pc = addr[21:0], instr = data, mask ignored.
  - CSR: write updates the register at the N→N+1 edge, mask ignored; read captures the CSR value into data_r at N.
  - INVALID: no side effect; invalid_epa_access_o = 1 in cycle N.
- Response contents, appearing at N+1 (latency 1):
  - Store returns type e_return_credit with data 0.
  - Load returns e_return_float_wb if packet_float_wb_i, else e_return_int_wb; reg_id is carried through.
  - INVALID load returns data 0.
- DMEM load data path:
  - live_r = 1 at N+1, and returning_data_o = dmem_data_i.
  - If the response is not taken at N+1, dmem_data_i is latched into data_r and live_r clears.
  - The response then holds stable until returning_ready_i.
- Backpressure: returning_v_o and its fields are held stable until returning_ready_i. With ready tied high, throughput is one request per cycle (back-to-back accept).
- Simultaneous CSR write and output: the new CSR value is visible on the *_o output from N+1.
- Reset (reset_n_i low), asynchronous:
  - freeze_o=1; tgo_x_o, tgo_y_o, pc_init_val_o, dram_enable_o = 0.
  - resp_v_r=0, so returning_v_o=0 immediately, even mid-held-response; that response is dropped.
  - packet_yumi_o, dmem_v_o, icache_v_o, invalid_epa_access_o forced to 0 while reset is low.

Decomposition:
- Shared package bsg_vanilla_pkg gets:
  - CSR offset enum: e_csr_freeze=0, e_csr_tgo_x, e_csr_tgo_y, e_csr_pc_init, e_csr_dram_enable.
  - Constants csr_base_addr_gp = 0x2000 and icache_sel_bit_gp = 22.
- Return packet types come from bsg_manycore_pkg.
- One sub-module: network_rx_csr, the CSR register file with write/read ports and reset values.

Test Plan:
- Reset: hold reset_n_i low → freeze_o=1, returning_v_o=0. Release, then store 0 to word 0x2000 → freeze_o=0 at N+1 and a credit is returned.
- DMEM store: addr 0x5, data 0xDEADBEEF, mask 0xF, dmem_yumi_i=1 → dmem_v_o=dmem_w_o=1 at N; credit return at N+1.
- DMEM load held: addr 0x5, reg 7, returning_ready_i=0 for 3 cycles, dmem_data_i=0xDEADBEEF only at N+1 → data stays 0xDEADBEEF, type int_wb, reg 7; packet_yumi_o=0 until drained.
- CSR round trip: store 0x1234 to 0x2003, then load 0x2003 with float_wb=1 → pc_init_val_o=0x1234; return float_wb with data 0x1234.
- Invalid: store to 0x3000 → invalid_epa_access_o pulses one cycle, no dmem_v_o or icache_v_o, credit returned. A load from icache space returns int_wb with data 0.
- Stall plus reset: dmem_yumi_i=0 for 2 cycles → no accept. Then two back-to-back loads with ready=1 → yumi on consecutive cycles. Assert reset while the second response is pending → returning_v_o drops at once.
